pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_pkg.sv | 17 +
 rtl/pipe_sat_counter.sv | 44 ++++
 rtl/pipe_stage_skid.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Purpose    : shared types and constants for the pipe_stage_skid block.
// Latency    : n/a (declarations only).
// Backpressure: n/a.
// Contents   : state_e (EMPTY/BUSY/FULL occupancy of the skid stage), PERF_CNT_W.
package pipe_stage_pkg;

   localparam int PERF_CNT_W = 32;

   // EMPTY: nothing held; BUSY: main register holds the entry shown downstream;
   // FULL: main and skid both hold entries, upstream is refused.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Purpose    : W-bit up-counter that sticks at all-ones instead of wrapping.
// Latency    : count visible one cycle after the inc/clr/ld cycle.
// Backpressure: none; inc is sampled every cycle.
// Ports      : clk, rst_n (async active-low), clr (zero, highest priority),
//              ld/ld_val (load a value), inc (count up by one), cnt (current value).
module pipe_sat_counter
   import pipe_stage_pkg::*;
#(
   parameter int W = PERF_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (ld) begin
         cnt_d = ld_val;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Purpose    : 2-entry skid-buffered pipeline register (main + skid) for WB-style entries.
// Latency    : 1 cycle from upstream transfer to dn_valid.
// Backpressure: up_ready is a flop (low only in FULL), so dn_ready never reaches up_ready combinationally.
// Ports      : clk, rst_n (async active-low), flush (sync kill of held entries),
//              up_valid/up_ready/up_ctrl/up_data/up_dest (upstream handshake + payload),
//              dn_valid/dn_ready/dn_ctrl/dn_data/dn_dest (downstream handshake + payload),
//              perf_clr, stall_cnt, bubble_cnt (performance counters).
// Option     : define PIPE_STAGE_SKID_PERF_EN to build the stall/bubble counters;
//              otherwise both counters read 0 and perf_clr is ignored.
module pipe_stage_skid
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = 3,
   parameter int DATA_W = 32,
   parameter int NDATA  = 3,
   parameter int DEST_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    up_valid,
   output logic                    up_ready,
   input  logic [CTRL_W-1:0]       up_ctrl,
   input  logic [NDATA*DATA_W-1:0] up_data,
   input  logic [DEST_W-1:0]       up_dest,
   output logic                    dn_valid,
   input  logic                    dn_ready,
   output logic [CTRL_W-1:0]       dn_ctrl,
   output logic [NDATA*DATA_W-1:0] dn_data,
   output logic [DEST_W-1:0]       dn_dest,
   input  logic                    perf_clr,
   output logic [PERF_CNT_W-1:0]   stall_cnt,
   output logic [PERF_CNT_W-1:0]   bubble_cnt
);

   typedef struct packed {
      logic [CTRL_W-1:0]       ctrl;
      logic [NDATA*DATA_W-1:0] data;
      logic [DEST_W-1:0]       dest;
   } entry_t;

   state_e state_q, state_d;
   entry_t main_q,  main_d;
   entry_t skid_q,  skid_d;
   logic   up_ready_q, up_ready_d;
   logic   dn_valid_q, dn_valid_d;
   entry_t up_ent;

   assign up_ent = '{ctrl: up_ctrl, data: up_data, dest: up_dest};

   // up_ready_q is 1 in EMPTY and BUSY, so in those states up_valid alone
   // means an upstream transfer; in FULL nothing is accepted.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Payload registers keep stale contents; dn_valid=0 masks them.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (up_valid) begin
                  main_d  = up_ent;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               case ({up_valid, dn_ready})
                  2'b11: main_d = up_ent;
                  2'b01: state_d = EMPTY;
                  2'b10: begin
                     // Downstream stalled: park the new entry behind main.
                     skid_d  = up_ent;
                     state_d = FULL;
                  end
                  default: ;
               endcase
            end
            FULL: begin
               if (dn_ready) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      up_ready_d = (state_d != FULL);
      dn_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         up_ready_q <= 1'b1;
         dn_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         up_ready_q <= up_ready_d;
         dn_valid_q <= dn_valid_d;
      end
   end

   assign up_ready = up_ready_q;
   assign dn_valid = dn_valid_q;
   // A bubble must never present a live reg_write, so ctrl is gated by valid.
   assign dn_ctrl  = dn_valid_q ? main_q.ctrl : {CTRL_W{1'b0}};
   assign dn_data  = main_q.data;
   assign dn_dest  = main_q.dest;

`ifdef PIPE_STAGE_SKID_PERF_EN
   pipe_sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (perf_clr),
      .inc    (dn_valid_q & ~dn_ready),
      .ld     (1'b0),
      .ld_val ({PERF_CNT_W{1'b0}}),
      .cnt    (stall_cnt)
   );

   pipe_sat_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (perf_clr),
      .inc    (~dn_valid_q),
      .ld     (1'b0),
      .ld_val ({PERF_CNT_W{1'b0}}),
      .cnt    (bubble_cnt)
   );
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign stall_cnt       = {PERF_CNT_W{1'b0}};
   assign bubble_cnt      = {PERF_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
   import pipe_stage_pkg::*;

   localparam int CTRL_W = 3;
   localparam int DATA_W = 32;
   localparam int NDATA  = 3;
   localparam int DEST_W = 5;
`ifdef PIPE_STAGE_SKID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                    clk;
   logic                    rst_n;
   logic                    flush;
   logic                    up_valid;
   logic                    up_ready;
   logic [CTRL_W-1:0]       up_ctrl;
   logic [NDATA*DATA_W-1:0] up_data;
   logic [DEST_W-1:0]       up_dest;
   logic                    dn_valid;
   logic                    dn_ready;
   logic [CTRL_W-1:0]       dn_ctrl;
   logic [NDATA*DATA_W-1:0] dn_data;
   logic [DEST_W-1:0]       dn_dest;
   logic                    perf_clr;
   logic [31:0]             stall_cnt;
   logic [31:0]             bubble_cnt;

   logic                    sc_clr, sc_inc, sc_ld;
   logic [31:0]             sc_ld_val, sc_cnt;

   pipe_stage_skid #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NDATA(NDATA), .DEST_W(DEST_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .up_valid(up_valid), .up_ready(up_ready), .up_ctrl(up_ctrl),
      .up_data(up_data), .up_dest(up_dest),
      .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_ctrl(dn_ctrl),
      .dn_data(dn_data), .dn_dest(dn_dest),
      .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_sat_counter #(.W(32)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(sc_clr), .inc(sc_inc),
      .ld(sc_ld), .ld_val(sc_ld_val), .cnt(sc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [CTRL_W-1:0]       ctrl;
      logic [NDATA*DATA_W-1:0] data;
      logic [DEST_W-1:0]       dest;
   } ent_t;

   // Reference model: an in-order queue of held entries, at most 2 deep.
   ent_t              mq[$];
   logic [DEST_W-1:0] outq[$];
   logic [31:0]       m_stall, m_bubble;
   int                total, bad, acc;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_payload();
      up_ctrl = CTRL_W'($urandom);
      up_data = {$urandom, $urandom, $urandom};
   endtask

   // Called just after a rising edge with inputs already driven: checks the
   // cycle's outputs against the model, then advances the model over the edge.
   task automatic step();
      logic dv, ur;
      ent_t e;
      @(negedge clk);
      dv = (mq.size() > 0);
      ur = (mq.size() < 2);
      chk("dn_valid", 128'(dn_valid), 128'(dv));
      chk("up_ready", 128'(up_ready), 128'(ur));
      if (dv) begin
         chk("dn_dest", 128'(dn_dest), 128'(mq[0].dest));
         chk("dn_data", 128'(dn_data), 128'(mq[0].data));
         chk("dn_ctrl", 128'(dn_ctrl), 128'(mq[0].ctrl));
      end else begin
         chk("dn_ctrl_bubble", 128'(dn_ctrl), 128'(0));
      end
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
      if (PERF) begin
         if (perf_clr) begin
            m_stall  = 32'd0;
            m_bubble = 32'd0;
         end else begin
            if (dv && !dn_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (!dv && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
         end
      end
      if (flush) begin
         mq.delete();
      end else begin
         if (dv && dn_ready) begin
            outq.push_back(mq[0].dest);
            void'(mq.pop_front());
         end
         if (up_valid && ur) begin
            e.ctrl = up_ctrl;
            e.data = up_data;
            e.dest = up_dest;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0; acc = 0;
      m_stall = 32'd0; m_bubble = 32'd0;
      rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
      up_ctrl = '0; up_data = '0; up_dest = '0; perf_clr = 1'b0;
      sc_clr = 1'b0; sc_inc = 1'b0; sc_ld = 1'b0; sc_ld_val = 32'd0;

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dn_valid", 128'(dn_valid), 128'(0));
      chk("rst_up_ready", 128'(up_ready), 128'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_dn_valid", 128'(dn_valid), 128'(0));
      chk("post_rst_up_ready", 128'(up_ready), 128'(1));
      chk("post_rst_dn_ctrl", 128'(dn_ctrl), 128'(0));
      chk("post_rst_stall", 128'(stall_cnt), 128'(0));
      chk("post_rst_bubble", 128'(bubble_cnt), 128'(0));
      @(posedge clk);
      #1;
      if (PERF) m_bubble = 32'd1;   // one idle edge elapsed since reset release

      // Streaming: 8 back-to-back entries, dest 1..8
      dn_ready = 1'b1;
      outq.delete();
      for (int i = 1; i <= 8; i++) begin
         up_valid = 1'b1;
         up_dest  = DEST_W'(i);
         rand_payload();
         step();
         chk("stream_valid", 128'(dn_valid), 128'(1));
         chk("stream_dest", 128'(dn_dest), 128'(i));
      end
      up_valid = 1'b0;
      step();
      chk("stream_count", 128'(outq.size()), 128'(8));
      for (int k = 0; k < 8 && k < outq.size(); k++)
         chk("stream_order", 128'(outq[k]), 128'(k + 1));

      // Backpressure: 3 entries offered with dn_ready low
      outq.delete();
      dn_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         up_valid = 1'b1;
         up_dest  = DEST_W'(acc + 1);
         rand_payload();
         if (up_ready) acc++;
         step();
         chk("bp_hold_dest", 128'(dn_dest), 128'(1));
      end
      chk("bp_accepted", 128'(acc), 128'(2));
      chk("bp_up_ready", 128'(up_ready), 128'(0));

      // Release: entries 1, 2, 3 must come out in order
      dn_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         up_valid = (acc < 3);
         up_dest  = DEST_W'(acc + 1);
         if (up_valid && up_ready) acc++;
         step();
      end
      up_valid = 1'b0;
      chk("rel_accepted", 128'(acc), 128'(3));
      chk("rel_count", 128'(outq.size()), 128'(3));
      for (int k = 0; k < 3 && k < outq.size(); k++)
         chk("rel_order", 128'(outq[k]), 128'(k + 1));

      // Flush in FULL with a same-cycle offer
      outq.delete();
      dn_ready = 1'b0;
      up_valid = 1'b1; up_dest = 5'd10; rand_payload(); step();
      up_dest = 5'd11; rand_payload(); step();
      chk("fl_full", 128'(up_ready), 128'(0));
      flush = 1'b1; up_dest = 5'd31; up_ctrl = 3'b111; step();
      flush = 1'b0; up_valid = 1'b0;
      chk("fl_dn_valid", 128'(dn_valid), 128'(0));
      chk("fl_dn_ctrl", 128'(dn_ctrl), 128'(0));
      chk("fl_up_ready", 128'(up_ready), 128'(1));
      dn_ready = 1'b1;
      repeat (3) step();
      chk("fl_nothing_out", 128'(outq.size()), 128'(0));

      // Performance counters
      perf_clr = 1'b1; up_valid = 1'b1; up_dest = 5'd5; dn_ready = 1'b0; rand_payload();
      step();
      perf_clr = 1'b0; up_valid = 1'b0;
      repeat (5) step();
      chk("perf_stall5", 128'(stall_cnt), PERF ? 128'(5) : 128'(0));
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
      chk("perf_clr_stall", 128'(stall_cnt), 128'(0));
      dn_ready = 1'b1;
      step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         up_valid = 1'($urandom_range(0, 1));
         dn_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 24) == 0);
         perf_clr = ($urandom_range(0, 39) == 0);
         up_dest  = DEST_W'($urandom);
         rand_payload();
         step();
      end
      flush = 1'b0; perf_clr = 1'b0;

      // Reset asserted mid-cycle while entries are held
      up_valid = 1'b1; dn_ready = 1'b0; rand_payload();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dn_valid", 128'(dn_valid), 128'(0));
      chk("async_rst_up_ready", 128'(up_ready), 128'(1));
      chk("async_rst_dn_ctrl", 128'(dn_ctrl), 128'(0));
      chk("async_rst_stall", 128'(stall_cnt), 128'(0));
      chk("async_rst_bubble", 128'(bubble_cnt), 128'(0));
      mq.delete();
      m_stall = 32'd0; m_bubble = 32'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      up_valid = 1'b1; up_dest = 5'd7; dn_ready = 1'b1; rand_payload();
      step();
      chk("first_accept_valid", 128'(dn_valid), 128'(1));
      chk("first_accept_dest", 128'(dn_dest), 128'(7));
      up_valid = 1'b0;
      step();

      // Saturating counter: preload, hold at max, clear priority
      sc_ld = 1'b1; sc_ld_val = 32'hFFFF_FFFE;
      @(posedge clk); #1;
      sc_ld = 1'b0; sc_inc = 1'b1;
      @(posedge clk); #1;
      chk("sat_reach_max", 128'(sc_cnt), 128'(32'hFFFF_FFFF));
      sc_inc = 1'b0; sc_ld = 1'b1; sc_ld_val = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      sc_ld = 1'b0; sc_inc = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", 128'(sc_cnt), 128'(32'hFFFF_FFFF));
      sc_clr = 1'b1;
      @(posedge clk); #1;
      chk("sat_clr_prio", 128'(sc_cnt), 128'(0));
      sc_clr = 1'b0;
      @(posedge clk); #1;
      chk("sat_inc_after_clr", 128'(sc_cnt), 128'(1));
      sc_inc = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
